// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared funct codes and state encoding for the multiply/divide unit
package mult_div_unit_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // Visible to the hazard unit so it can reason about the stall window.
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_mult_div(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one radix-2 step: shift-add multiply or restoring shift-subtract divide
module mdu_iter_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_div_i,
  input  logic [DATA_WIDTH:0]   acc_i,
  input  logic [DATA_WIDTH-1:0] low_i,
  input  logic [DATA_WIDTH:0]   operand_i,
  output logic [DATA_WIDTH:0]   acc_o,
  output logic [DATA_WIDTH-1:0] low_o
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W+1:0] diff;

  always_comb begin
    sum     = acc_i + (low_i[0] ? operand_i : '0);
    shifted = {acc_i[W-1:0], low_i[W-1]};
    diff    = {1'b0, shifted} - {1'b0, operand_i};
    if (is_div_i) begin
      // A borrow means the trial subtraction failed: keep the shifted remainder.
      if (diff[W+1]) begin
        acc_o = shifted;
        low_o = {low_i[W-2:0], 1'b0};
      end else begin
        acc_o = diff[W:0];
        low_o = {low_i[W-2:0], 1'b1};
      end
    end else begin
      acc_o = {1'b0, sum[W:1]};
      low_o = {sum[0], low_i[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [5:0]            instr_funct_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  input  logic                  kill_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    acc_q, acc_d;
  logic [W-1:0]  low_q, low_d;
  logic [W:0]    opnd_q, opnd_d;
  logic          is_div_q, is_div_d;
  logic          res_neg_q, res_neg_d;
  logic          rem_neg_q, rem_neg_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          done_q, done_d;

  logic          accept;
  logic          op_signed;
  logic          rs_neg;
  logic          rt_neg;
  logic [W-1:0]  rs_mag;
  logic [W:0]    rt_mag;
  logic [W:0]    step_acc;
  logic [W-1:0]  step_low;
  logic [2*W-1:0] product;
  logic [2*W-1:0] product_fix;
  logic [W-1:0]  quot_fix;
  logic [W-1:0]  rem_fix;

  mdu_iter_step #(.DATA_WIDTH(W)) u_step (
    .is_div_i  (is_div_q),
    .acc_i     (acc_q),
    .low_i     (low_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc),
    .low_o     (step_low)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign accept = start_i && !kill_i;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MDU_IDLE: if (accept && is_mult_div(instr_funct_i)) state_d = MDU_RUN;
      MDU_RUN: begin
        if (kill_i) state_d = MDU_IDLE;
        else if (cnt_q == LAST_STEP) state_d = MDU_FIX;
      end
      MDU_FIX: state_d = MDU_IDLE;
      default: state_d = MDU_IDLE;
    endcase
  end

  // Operand magnitudes; -0x80000000 is representable as an unsigned W-bit magnitude.
  always_comb begin
    op_signed = (instr_funct_i == FUNCT_MULT) || (instr_funct_i == FUNCT_DIV);
    rs_neg    = op_signed && rs_data_i[W-1];
    rt_neg    = op_signed && rt_data_i[W-1];
    rs_mag    = rs_neg ? (-rs_data_i) : rs_data_i;
    rt_mag    = rt_neg ? (-{1'b1, rt_data_i}) : {1'b0, rt_data_i};
  end

  always_comb begin
    product     = {acc_q[W-1:0], low_q};
    product_fix = res_neg_q ? (-product) : product;
    quot_fix    = res_neg_q ? (-low_q) : low_q;
    rem_fix     = rem_neg_q ? (-acc_q[W-1:0]) : acc_q[W-1:0];
  end

  // Datapath and HI/LO updates
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          if (instr_funct_i == FUNCT_MTHI) begin
            hi_d = rs_data_i;
          end else if (instr_funct_i == FUNCT_MTLO) begin
            lo_d = rs_data_i;
          end else if (is_mult_div(instr_funct_i)) begin
            is_div_d  = (instr_funct_i == FUNCT_DIV) || (instr_funct_i == FUNCT_DIVU);
            cnt_d     = '0;
            acc_d     = '0;
            low_d     = rs_mag;
            opnd_d    = rt_mag;
            // A zero divisor must leave the all-ones quotient un-negated.
            res_neg_d = (rs_neg ^ rt_neg) && !(is_div_d && (rt_data_i == '0));
            rem_neg_d = rs_neg;
          end
        end
      end
      MDU_RUN: begin
        if (!kill_i) begin
          acc_d = step_acc;
          low_d = step_low;
          cnt_d = cnt_q + 1'b1;
        end
      end
      MDU_FIX: begin
        if (!kill_i) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = product_fix[2*W-1:W];
            lo_d = product_fix[W-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = (state_q != MDU_IDLE);
    done_o = done_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized bench for mult_div_unit against an arithmetic reference
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [5:0]  funct = 6'h00;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o;

  always #5 clk = ~clk;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .instr_funct_i (funct),
    .rs_data_i     (rs),
    .rt_data_i     (rt),
    .kill_i        (kill_i),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void ref_calc(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    h = '0;
    l = '0;
    case (f)
      6'h18: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        h = sp[63:32];
        l = sp[31:0];
      end
      6'h19: begin
        up = {32'b0, a} * {32'b0, b};
        h = up[63:32];
        l = up[31:0];
      end
      6'h1A: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = 32'h80000000; end
        else begin l = sa / sb; h = sa % sb; end
      end
      6'h1B: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Cycle-level behavioural model: a countdown of remaining busy cycles plus pending result.
  int          remaining = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;
  logic        exp_done = 1'b0;

  always @(posedge clk) begin
    exp_done = 1'b0;
    if (reset) begin
      remaining = 0;
      exp_hi = '0;
      exp_lo = '0;
    end else if (remaining > 0) begin
      if (kill_i) remaining = 0;
      else begin
        remaining--;
        if (remaining == 0) begin
          exp_hi = pend_hi;
          exp_lo = pend_lo;
          exp_done = 1'b1;
        end
      end
    end else if (start_i && !kill_i) begin
      case (funct)
        6'h11: exp_hi = rs;
        6'h13: exp_lo = rs;
        6'h18, 6'h19, 6'h1A, 6'h1B: begin
          ref_calc(funct, rs, rt, pend_hi, pend_lo);
          remaining = 33;
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy", {63'b0, busy_o}, {63'b0, remaining > 0});
      chk("done", {63'b0, done_o}, {63'b0, exp_done});
      chk("hi", {32'b0, hi_o}, {32'b0, exp_hi});
      chk("lo", {32'b0, lo_o}, {32'b0, exp_lo});
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i = 1'b1;
    funct = f;
    rs = a;
    rt = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int nb, nd;
    issue(f, a, b);
    nb = 0;
    nd = 0;
    repeat (40) begin
      nb += busy_o;
      nd += done_o;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, nb, 33);
    chk({name, "_done_pulses"}, nd, 1);
    chk({name, "_hi"}, hi_o, eh);
    chk({name, "_lo"}, lo_o, el);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] tbl [10] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10, 6'h12, 6'h20, 6'h00};
    return tbl[$urandom % 10];
  endfunction

  initial begin
    logic [31:0] mh, ml;
    int nd;

    ref_calc(6'h18, 32'hFFFFFFFD, 32'd7, mh, ml);
    chk("model_mult", {mh, ml}, 64'hFFFFFFFF_FFFFFFEB);
    ref_calc(6'h1A, 32'hFFFFFFF9, 32'd2, mh, ml);
    chk("model_div", {mh, ml}, 64'hFFFFFFFF_FFFFFFFD);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_hi", hi_o, 0);
    chk("reset_lo", lo_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);

    run_check("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_check("mult_neg", 6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_check("div_neg", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_check("divu_zero", 6'h1B, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run_check("div_zero_neg", 6'h1A, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_check("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // kill at cycle 10 of a MULT: HI/LO keep the overflow-divide result
    issue(6'h18, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_busy", busy_o, 0);
    chk("kill_hi", hi_o, 32'h0);
    chk("kill_lo", lo_o, 32'h80000000);
    nd = 0;
    repeat (40) begin nd += done_o; @(negedge clk); end
    chk("kill_no_done", nd, 0);

    // MTHI then MTLO back-to-back
    start_i = 1'b1; funct = 6'h11; rs = 32'h1234;
    @(negedge clk);
    chk("mthi_hi", hi_o, 32'h1234);
    chk("mthi_busy", busy_o, 0);
    funct = 6'h13; rs = 32'h5678;
    @(negedge clk);
    start_i = 1'b0;
    chk("mtlo_lo", lo_o, 32'h5678);
    chk("mtlo_hi", hi_o, 32'h1234);
    chk("mtlo_busy", busy_o, 0);

    // MTHI issued while a MULT is in flight is ignored
    issue(6'h18, 32'h10000, 32'h10000);
    repeat (5) @(negedge clk);
    start_i = 1'b1; funct = 6'h11; rs = 32'hDEAD;
    @(negedge clk);
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("mthi_busy_hi", hi_o, 32'h1);
    chk("mthi_busy_lo", lo_o, 32'h0);

    // reset at cycle 20 of a MULT
    issue(6'h18, 32'h7, 32'h9);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_hi", hi_o, 0);
    chk("rst_mid_lo", lo_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_done", done_o, 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start_i = ($urandom % 3) == 0;
      funct = pick_funct();
      rs = pick_val();
      rt = pick_val();
      kill_i = ($urandom % 60) == 0;
    end
    @(negedge clk);
    start_i = 1'b0;
    kill_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("final_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage alongside the ALU.
- Consumes the funct field and register operands for MULT/MULTU/DIV/DIVU/MTHI/MTLO once the decoder has classified the instruction as R-type.
- Raises busy_o so the hazard logic stalls MFHI/MFLO and further mult/div ops until the result has landed in HI/LO.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  EX-stage instruction targets this unit (qualified R-type, pipeline not stalled).
- instr_funct_i  input  6  funct code: MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B, MTHI 6'h11, MTLO 6'h13; other codes ignored.
- rs_data_i  input  DATA_WIDTH  multiplicand/dividend, or MTHI/MTLO source.
- rt_data_i  input  DATA_WIDTH  multiplier/divisor.
- kill_i  input  1  abort in-flight op (older-instruction exception/flush).
- hi_o  output  DATA_WIDTH  HI register, registered.
- lo_o  output  DATA_WIDTH  LO register, registered.
- busy_o  output  1  state != IDLE; stall request.
- done_o  output  1  one-cycle pulse in the cycle after HI/LO are written by MULT*/DIV*.

Behaviour:
- Reset:
  - Applies mid-operation too.
  - state=IDLE, HI=0, LO=0, busy_o=0, done_o=0, iteration counter=0, working registers=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start_i && !kill_i && MTHI: HI<=rs_data_i next edge; state stays IDLE; busy_o stays 0; no done_o.
  - start_i && !kill_i && MTLO: same as MTHI, writing LO.
  - start_i && !kill_i && MULT*/DIV*: capture operands; for signed ops capture magnitudes and record result signs; counter<=0; state<=RUN.
  - Unknown funct: no effect.
- RUN:
  - One radix-2 step per cycle, counter+1.
  - Multiply: shift-add into 2*DATA_WIDTH product.
  - Divide: restoring shift-subtract producing quotient/remainder.
  - After DATA_WIDTH steps: state<=FIX.
- FIX:
  - Apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO: MULT* gives HI=product[63:32], LO=product[31:0]; DIV* gives HI=remainder, LO=quotient.
  - state<=IDLE; done_o=1 for the following cycle.
- Latency:
  - Op sampled at edge E0; busy_o high for DATA_WIDTH+1 cycles (33).
  - HI/LO updated at edge E33; done_o high during cycle E33..E34.
  - hi_o/lo_o hold their old values throughout RUN/FIX.
- start_i while busy: ignored (hazard logic must not issue it). No queueing and no corruption of the in-flight op.
- kill_i:
  - In RUN/FIX: state<=IDLE next edge, HI/LO unchanged, no done_o.
  - In IDLE with start_i: kill wins, nothing captured (including MTHI/MTLO).
- Divide by zero (signed or unsigned): HI=rs_data_i, LO=all ones; still takes the full 33 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Arithmetic:
  - Magnitude of 0x80000000 is computed in DATA_WIDTH+1 bits; no truncation.
  - MULTU/DIVU treat operands as unsigned with no sign fix.

Decomposition:
- Funct constants come from the shared MIPS instruction defines include; do not redefine them locally.
- State encoding (IDLE/RUN/FIX) lives in a small shared package/include for the hazard unit's visibility.
- One sub-module is natural: mdu_iter_step, the combinational single-cycle shift-add/shift-subtract step, instantiated once.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy_o 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, done_o single pulse.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU rs=100, rt=0 -> HI=100, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MTLO 0x5678 back-to-back -> HI=0x1234, LO=0x5678 one edge after each, busy_o never asserted; MTHI issued during a MULT -> ignored, MULT result intact.
- MULT started, kill_i at cycle 10 -> busy_o drops next cycle, HI/LO retain prior values, no done_o.
- MULT started, reset at cycle 20 -> HI=LO=0, IDLE next cycle.
